mdio_link_scheduler: RTL

- Sequences all accesses to the shared MDIO master engine that drives mdc/mdio.
- On a start pulse, writes a fixed 3-entry PHY configuration table, then periodically polls BMSR for link status.
- Reports init completion, link state, link-change events and access timeouts to the top level, e.g. for LED status.

---
 rtl/mdio_link_scheduler.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_link_scheduler.sv
//------------------------------------------------------------------------------
// mdio_link_scheduler
//
// Purpose:
//   Sequences every access to the shared MDIO master engine. A start pulse
//   writes a fixed three-entry PHY configuration table. The block then polls
//   BMSR periodically and reports the link state. Each access is guarded by a
//   timeout that aborts the sequence and raises a sticky error flag.
//
// Optional feature (compile-time macro MDIO_SPEED_POLL_EN):
//   When the macro is defined, each poll round ends with a read of PHY
//   register 0x11, which updates speed/duplex. When it is undefined, speed and
//   duplex are tied to zero and register 0x11 is never accessed.
//
// Parameters:
//   POLL_CYC     sys_clk cycles between poll rounds (minimum 4)
//   TIMEOUT_CYC  cycles op_req may stay high without op_done before abort
//   PHY_ADDR     PHY address driven on op_phy_addr
//
// Ports:
//   sys_clk, sys_rst_n   clock (rising edge), asynchronous active-low reset
//   start                single-cycle pulse: begin / restart the init table
//   op_req .. op_wdata   request to the MDIO engine (registered, held stable)
//   op_done, op_rdata    completion pulse and read data from the engine
//   busy                 access outstanding or init table in progress
//   init_done            table fully written (cleared by start or timeout)
//   link_up, link_change last sampled BMSR bit 2 and its 1-cycle change pulse
//   err                  sticky access-timeout flag
//   speed, duplex        PHY speed/duplex (optional feature, else 0)
//------------------------------------------------------------------------------
module mdio_link_scheduler #(
    parameter int         POLL_CYC    = 5000000,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [4:0] PHY_ADDR    = 5'h01
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        op_req,
    output logic        op_wr,
    output logic [4:0]  op_phy_addr,
    output logic [4:0]  op_reg_addr,
    output logic [15:0] op_wdata,
    input  logic        op_done,
    input  logic [15:0] op_rdata,
    output logic        busy,
    output logic        init_done,
    output logic        link_up,
    output logic        link_change,
    output logic        err,
    output logic [1:0]  speed,
    output logic        duplex
);

    localparam int PT_W = $clog2(POLL_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PT_W-1:0] POLL_LAST = PT_W'(POLL_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [4:0] REG_BMSR = 5'h01;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT_REQ  = 3'd1;
    localparam logic [2:0] ST_POLL_WAIT = 3'd2;
    localparam logic [2:0] ST_RD1_REQ   = 3'd3;
    localparam logic [2:0] ST_RD2_REQ   = 3'd4;
`ifdef MDIO_SPEED_POLL_EN
    localparam logic [2:0] ST_SPD_REQ   = 3'd5;
    localparam logic [4:0] REG_SPEED    = 5'h11;
`endif

    logic [2:0]      state;
    logic [1:0]      idx;
    logic [PT_W-1:0] poll_tmr;
    logic [TO_W-1:0] to_cnt;

    // Init table: register address per entry
    function automatic logic [4:0] tbl_reg(input logic [1:0] i);
        case (i)
            2'd0:    return 5'h04;
            default: return 5'h00;
        endcase
    endfunction

    // Init table: write data per entry
    function automatic logic [15:0] tbl_data(input logic [1:0] i);
        case (i)
            2'd0:    return 16'h01E1;
            2'd1:    return 16'h1140;
            default: return 16'h1340;
        endcase
    endfunction

    assign busy = op_req | (state == ST_INIT_REQ);

`ifdef MDIO_SPEED_POLL_EN
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^{op_rdata[12:3], op_rdata[1:0]};
`else
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^{op_rdata[15:3], op_rdata[1:0]};
    assign speed  = 2'b00;
    assign duplex = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            poll_tmr    <= '0;
            to_cnt      <= '0;
            op_req      <= 1'b0;
            op_wr       <= 1'b0;
            op_phy_addr <= 5'h00;
            op_reg_addr <= 5'h00;
            op_wdata    <= 16'h0000;
            init_done   <= 1'b0;
            link_up     <= 1'b0;
            link_change <= 1'b0;
            err         <= 1'b0;
`ifdef MDIO_SPEED_POLL_EN
            speed       <= 2'b00;
            duplex      <= 1'b0;
`endif
        end else begin
            link_change <= 1'b0;

            // A start can only be taken between accesses; while a request is
            // outstanding the engine owns the bus and the pulse is dropped.
            if (start && !op_req) begin
                state     <= ST_INIT_REQ;
                idx       <= 2'd0;
                err       <= 1'b0;
                init_done <= 1'b0;
                poll_tmr  <= '0;
            end else if (op_req) begin
                // op_done beats a timeout that expires in the same cycle
                if (op_done) begin
                    op_req <= 1'b0;
                    case (state)
                        ST_INIT_REQ: begin
                            if (idx == 2'd2) begin
                                init_done <= 1'b1;
                                poll_tmr  <= '0;
                                state     <= ST_POLL_WAIT;
                            end else begin
                                idx <= idx + 2'd1;
                            end
                        end
                        // First BMSR read only clears the latched-low link bit
                        ST_RD1_REQ: state <= ST_RD2_REQ;
                        ST_RD2_REQ: begin
                            link_up     <= op_rdata[2];
                            link_change <= (op_rdata[2] != link_up);
`ifdef MDIO_SPEED_POLL_EN
                            state       <= ST_SPD_REQ;
`else
                            poll_tmr    <= '0;
                            state       <= ST_POLL_WAIT;
`endif
                        end
`ifdef MDIO_SPEED_POLL_EN
                        ST_SPD_REQ: begin
                            // Speed/duplex are meaningless with the link down
                            if (link_up) begin
                                speed  <= op_rdata[15:14];
                                duplex <= op_rdata[13];
                            end
                            poll_tmr <= '0;
                            state    <= ST_POLL_WAIT;
                        end
`endif
                        default: state <= ST_IDLE;
                    endcase
                end else if (to_cnt == TO_LAST) begin
                    op_req    <= 1'b0;
                    err       <= 1'b1;
                    init_done <= 1'b0;
                    state     <= ST_IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                // op_req is low here, so any request raised below is always
                // preceded by at least one low cycle.
                case (state)
                    ST_INIT_REQ: begin
                        op_req      <= 1'b1;
                        op_wr       <= 1'b1;
                        op_phy_addr <= PHY_ADDR;
                        op_reg_addr <= tbl_reg(idx);
                        op_wdata    <= tbl_data(idx);
                        to_cnt      <= '0;
                    end
                    ST_POLL_WAIT: begin
                        if (poll_tmr == POLL_LAST) begin
                            poll_tmr <= '0;
                            state    <= ST_RD1_REQ;
                        end else begin
                            poll_tmr <= poll_tmr + 1'b1;
                        end
                    end
                    ST_RD1_REQ, ST_RD2_REQ: begin
                        op_req      <= 1'b1;
                        op_wr       <= 1'b0;
                        op_phy_addr <= PHY_ADDR;
                        op_reg_addr <= REG_BMSR;
                        op_wdata    <= 16'h0000;
                        to_cnt      <= '0;
                    end
`ifdef MDIO_SPEED_POLL_EN
                    ST_SPD_REQ: begin
                        op_req      <= 1'b1;
                        op_wr       <= 1'b0;
                        op_phy_addr <= PHY_ADDR;
                        op_reg_addr <= REG_SPEED;
                        op_wdata    <= 16'h0000;
                        to_cnt      <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
